// File: rtl/nx_fifo_pkg.sv
// nx_fifo_pkg: shared error-bit indices, err_status type and count helper for nx_fifo_wm.
// Build option NX_FIFO_PARITY_EN adds a parity bit per entry and a third sticky error bit.
package nx_fifo_pkg;

  localparam int ERR_UNF = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_PAR = 2;

`ifdef NX_FIFO_PARITY_EN
  localparam int ERR_W = 3;
  localparam int PAR_W = 1;
`else
  localparam int ERR_W = 2;
  localparam int PAR_W = 0;
`endif

  typedef logic [ERR_W-1:0] err_status_t;

  function automatic logic [31:0] fifo_cnt_next(input logic [31:0] cnt,
                                                input logic        wacc,
                                                input logic        racc);
    return cnt + 32'(wacc) - 32'(racc);
  endfunction

endpackage

// File: rtl/nx_fifo_ctrl_wm.sv
// nx_fifo_ctrl_wm: pointers, occupancy, watermark flags and error tracking for nx_fifo_wm.
// With NX_FIFO_PARITY_EN a par_err input feeds the sticky parity bit.
module nx_fifo_ctrl_wm
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wen,
  input  logic             ren,
  input  logic [AW:0]      afull_thresh,
  input  logic [AW:0]      aempty_thresh,
`ifdef NX_FIFO_PARITY_EN
  input  logic             par_err,
`endif
  output logic             write_acc,
  output logic             read_acc,
  output logic [AW-1:0]    wptr,
  output logic [AW-1:0]    rptr,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      used_slots,
  output logic [AW:0]      free_slots,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [ERR_W-1:0] err_status
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0] cnt_nxt;
  err_status_t err_nxt;

  // A pop at full frees the slot the simultaneous push needs.
  always_comb begin
    read_acc  = ren && !empty;
    write_acc = wen && (!full || read_acc);
    cnt_nxt   = (AW+1)'(fifo_cnt_next(32'(used_slots), write_acc, read_acc));
    err_nxt   = err_status;
    if (wen && !write_acc) err_nxt[ERR_OVF] = 1'b1;
    if (ren && empty)      err_nxt[ERR_UNF] = 1'b1;
`ifdef NX_FIFO_PARITY_EN
    if (par_err)           err_nxt[ERR_PAR] = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      used_slots   <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      err_status   <= '0;
    end else if (clear) begin
      wptr         <= '0;
      rptr         <= '0;
      used_slots   <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      err_status   <= '0;
    end else begin
      if (write_acc) wptr <= wptr + AW'(1);
      if (read_acc)  rptr <= rptr + AW'(1);
      used_slots   <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      full         <= (cnt_nxt == DEPTH_C);
      almost_full  <= (cnt_nxt >= afull_thresh);
      almost_empty <= (cnt_nxt <= aempty_thresh);
      overflow     <= wen && !write_acc;
      underflow    <= ren && empty;
      err_status   <= err_nxt;
    end
  end

  assign free_slots = DEPTH_C - used_slots;

endmodule

// File: rtl/nx_fifo_wm.sv
// nx_fifo_wm: parametrised single-clock FIFO with programmable watermarks and sticky errors.
// Define NX_FIFO_PARITY_EN to store an even-parity bit per entry and drive par_err.
module nx_fifo_wm
  import nx_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      used_slots,
  output logic [AW:0]      free_slots,
  input  logic [AW:0]      afull_thresh,
  input  logic [AW:0]      aempty_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [ERR_W-1:0] err_status,
  output logic             par_err
);

  localparam int MW = WIDTH + PAR_W;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wword;
  logic [MW-1:0] head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          write_acc;
  logic          read_acc;

  nx_fifo_ctrl_wm #(.DEPTH(DEPTH), .AW(AW)) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .wen           (wen),
    .ren           (ren),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
`ifdef NX_FIFO_PARITY_EN
    .par_err       (par_err),
`endif
    .write_acc     (write_acc),
    .read_acc      (read_acc),
    .wptr          (wptr),
    .rptr          (rptr),
    .empty         (empty),
    .full          (full),
    .used_slots    (used_slots),
    .free_slots    (free_slots),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow      (overflow),
    .underflow     (underflow),
    .err_status    (err_status)
  );

  assign head = mem[rptr];

`ifdef NX_FIFO_PARITY_EN
  assign wword   = {^wdata, wdata};
  assign par_err = !empty && (^head);
`else
  assign wword   = wdata;
  assign par_err = 1'b0;
`endif

  // No reset on the array so it maps onto the memory primitive.
  always_ff @(posedge clk) begin
    if (write_acc) mem[wptr] <= wword;
  end

  assign rdata = empty ? '0 : head[WIDTH-1:0];

endmodule

// File: tb/tb_nx_fifo_wm.sv
// tb_nx_fifo_wm: directed and randomized checks of nx_fifo_wm against a queue-based model.
module tb_nx_fifo_wm;
  import nx_fifo_pkg::*;

  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic [AW:0]      used_slots;
  logic [AW:0]      free_slots;
  logic [AW:0]      afull_thresh;
  logic [AW:0]      aempty_thresh;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [ERR_W-1:0] err_status;
  logic             par_err;

  nx_fifo_wm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .wen           (wen),
    .wdata         (wdata),
    .ren           (ren),
    .rdata         (rdata),
    .empty         (empty),
    .full          (full),
    .used_slots    (used_slots),
    .free_slots    (free_slots),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow      (overflow),
    .underflow     (underflow),
    .err_status    (err_status),
    .par_err       (par_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of stored words plus predicted flags.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf, m_unf, m_af, m_ae;
  logic [ERR_W-1:0] m_err;

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_af = 0; m_ae = 1;
    m_err = '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  // Drive one cycle, advance the model at the edge, return 1ns after it.
  task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit c);
    bit racc, wacc;
    int sz;
    wen = w; ren = r; wdata = d; clear = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      sz    = q.size();
      racc  = r && (sz > 0);
      wacc  = w && ((sz < DEPTH) || racc);
      m_ovf = w && !wacc;
      m_unf = r && (sz == 0);
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
      if (m_ovf) m_err[ERR_OVF] = 1'b1;
      if (m_unf) m_err[ERR_UNF] = 1'b1;
      m_af = (q.size() >= int'(afull_thresh));
      m_ae = (q.size() <= int'(aempty_thresh));
    end
    #1;
    wen = 0; ren = 0; clear = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; wen = 0; ren = 0; wdata = '0;
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    n_cmp++; if (used_slots !== 5'd0) begin n_bad++; $display("FAIL reset_used got=%0d exp=0", used_slots); end
    n_cmp++; if (free_slots !== 5'd16) begin n_bad++; $display("FAIL reset_free got=%0d exp=16", free_slots); end
    n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_wm got ae=%0b af=%0b exp ae=1 af=0", almost_empty, almost_full); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got ovf=%0b unf=%0b exp 0 0", overflow, underflow); end
    n_cmp++; if (err_status !== '0 || par_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got err=%0b par=%0b exp 0 0", err_status, par_err); end
    n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, WIDTH'(i), 0);
      n_cmp++; if (int'(used_slots) !== q.size()) begin n_bad++; $display("FAIL fill_used got=%0d exp=%0d", used_slots, q.size()); end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got=%0b exp=1", full); end
    n_cmp++; if (used_slots !== 5'd16 || free_slots !== 5'd0) begin n_bad++; $display("FAIL fill_counts got used=%0d free=%0d exp 16 0", used_slots, free_slots); end
    n_cmp++; if (rdata !== 64'h0) begin n_bad++; $display("FAIL fill_head got=%0h exp=0", rdata); end
    step(1, 0, 64'hDEAD, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got=%0b exp=1", overflow); end
    n_cmp++; if (err_status[1:0] !== 2'b10) begin n_bad++; $display("FAIL ovf_sticky got=%0b exp=10", err_status); end
    step(0, 0, '0, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_once got=%0b exp=0", overflow); end
    n_cmp++; if (used_slots !== 5'd16) begin n_bad++; $display("FAIL ovf_count got=%0d exp=16", used_slots); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 64'h100 + WIDTH'(i), 0);
      n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin n_bad++; $display("FAIL fullrw_flags got full=%0b ovf=%0b exp 1 0", full, overflow); end
      n_cmp++; if (rdata !== m_head()) begin n_bad++; $display("FAIL fullrw_rdata got=%0h exp=%0h", rdata, m_head()); end
    end
    while (q.size() > 0) begin
      step(0, 1, '0, 0);
      n_cmp++; if (rdata !== m_head() || int'(used_slots) !== q.size()) begin n_bad++; $display("FAIL drain got rdata=%0h used=%0d exp %0h %0d", rdata, used_slots, m_head(), q.size()); end
    end
  endtask

  task automatic test_empty_rw();
    step(1, 1, 64'hA5, 0);
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL emptyrw_unf got=%0b exp=1", underflow); end
    n_cmp++; if (used_slots !== 5'd1) begin n_bad++; $display("FAIL emptyrw_count got=%0d exp=1", used_slots); end
    step(0, 0, '0, 0);
    n_cmp++; if (rdata !== 64'hA5) begin n_bad++; $display("FAIL emptyrw_rdata got=%0h exp=a5", rdata); end
    n_cmp++; if (err_status[ERR_UNF] !== 1'b1 || underflow !== 1'b0) begin n_bad++; $display("FAIL emptyrw_sticky got err=%0b unf=%0b exp unf_seen=1 unf=0", err_status, underflow); end
    n_cmp++; if (err_status !== m_err) begin n_bad++; $display("FAIL emptyrw_err got=%0b exp=%0b", err_status, m_err); end
  endtask

  task automatic test_watermarks();
    step(0, 0, '0, 1);
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, WIDTH'(i), 0);
      n_cmp++; if (almost_empty !== m_ae || almost_full !== m_af) begin n_bad++; $display("FAIL wm_step%0d got ae=%0b af=%0b exp %0b %0b", i, almost_empty, almost_full, m_ae, m_af); end
      if (i == 3)  begin n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL wm_ae_at3 got=%0b exp=1", almost_empty); end end
      if (i == 4)  begin n_cmp++; if (almost_empty !== 1'b0) begin n_bad++; $display("FAIL wm_ae_at4 got=%0b exp=0", almost_empty); end end
      if (i == 11) begin n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL wm_af_at11 got=%0b exp=0", almost_full); end end
      if (i == 12) begin n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL wm_af_at12 got=%0b exp=1", almost_full); end end
    end
    aempty_thresh = 5'd16;
    n_cmp++; if (almost_empty !== 1'b0) begin n_bad++; $display("FAIL wm_thresh_latency got=%0b exp=0", almost_empty); end
    step(0, 0, '0, 0);
    n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL wm_ae_depth got=%0b exp=1", almost_empty); end
    step(0, 0, '0, 1);
    afull_thresh = 5'd0; aempty_thresh = 5'd3;
    step(0, 0, '0, 0);
    n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL wm_af_zero got=%0b exp=1", almost_full); end
    afull_thresh = 5'd12;
  endtask

  task automatic test_clear();
    step(0, 0, '0, 1);
    step(0, 1, '0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 64'h5000 + WIDTH'(i), 0);
    n_cmp++; if (used_slots !== 5'd7 || err_status === '0) begin n_bad++; $display("FAIL clear_pre got used=%0d err=%0b exp 7 nonzero", used_slots, err_status); end
    step(1, 1, 64'h77, 1);
    n_cmp++; if (empty !== 1'b1 || used_slots !== 5'd0) begin n_bad++; $display("FAIL clear_state got empty=%0b used=%0d exp 1 0", empty, used_slots); end
    n_cmp++; if (err_status !== '0 || rdata !== '0) begin n_bad++; $display("FAIL clear_err got err=%0b rdata=%0h exp 0 0", err_status, rdata); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_bad++; $display("FAIL clear_pulses got ovf=%0b unf=%0b exp 0 0", overflow, underflow); end
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        afull_thresh  = 5'($urandom_range(0, 17));
        aempty_thresh = 5'($urandom_range(0, 17));
      end
      // Bias towards fill or drain in phases so both full and empty are visited.
      w = ($urandom_range(0, 99) < (((i / 80) % 2 == 0) ? 70 : 30));
      r = ($urandom_range(0, 99) < (((i / 80) % 2 == 0) ? 30 : 70));
      c = ($urandom_range(0, 59) == 0);
      step(w, r, {$urandom, $urandom}, c);
      n_cmp++; if (rdata !== m_head()) begin n_bad++; $display("FAIL rnd_rdata cyc=%0d got=%0h exp=%0h", i, rdata, m_head()); end
      n_cmp++; if (int'(used_slots) !== q.size() || int'(free_slots) !== DEPTH - q.size()) begin n_bad++; $display("FAIL rnd_counts cyc=%0d got used=%0d free=%0d exp used=%0d", i, used_slots, free_slots, q.size()); end
      n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_ef cyc=%0d got empty=%0b full=%0b size=%0d", i, empty, full, q.size()); end
      n_cmp++; if (almost_full !== m_af || almost_empty !== m_ae) begin n_bad++; $display("FAIL rnd_wm cyc=%0d got af=%0b ae=%0b exp %0b %0b", i, almost_full, almost_empty, m_af, m_ae); end
      n_cmp++; if (overflow !== m_ovf || underflow !== m_unf) begin n_bad++; $display("FAIL rnd_pulse cyc=%0d got ovf=%0b unf=%0b exp %0b %0b", i, overflow, underflow, m_ovf, m_unf); end
      n_cmp++; if (err_status !== m_err) begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", i, err_status, m_err); end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, (i > 2), 64'h900 + WIDTH'(i), 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    n_cmp++; if (err_status === '0 || empty !== 1'b1) begin n_bad++; $display("FAIL arst_pre got err=%0b empty=%0b", err_status, empty); end
    step(1, 0, 64'h42, 0);
    step(1, 0, 64'h43, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || used_slots !== 5'd0 || free_slots !== 5'd16) begin n_bad++; $display("FAIL arst_counts got empty=%0b full=%0b used=%0d free=%0d", empty, full, used_slots, free_slots); end
    n_cmp++; if (rdata !== '0 || err_status !== '0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_bad++; $display("FAIL arst_outputs got rdata=%0h err=%0b ae=%0b af=%0b", rdata, err_status, almost_empty, almost_full); end
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 64'h1234, 0);
    n_cmp++; if (rdata !== 64'h1234 || par_err !== 1'b0) begin n_bad++; $display("FAIL arst_after got rdata=%0h par=%0b exp 1234 0", rdata, par_err); end
`ifdef NX_FIFO_PARITY_EN
    dut.mem[0] = dut.mem[0] ^ 65'h1;
    #1;
    n_cmp++; if (par_err !== 1'b1) begin n_bad++; $display("FAIL par_flip got=%0b exp=1", par_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_watermarks();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nx_fifo_wm.md
Name: nx_fifo_wm

Overview:
- Parametrised synchronous FIFO; next generation of the team's fixed 16x64 nx_fifo.
- Generalises width and depth.
- Adds runtime-programmable almost-full/almost-empty watermarks, sticky error status, and simultaneous read/write at full.
- Sits between datapath producers and consumers in a single clock domain.
- Storage maps to the emulator memory primitive; control lives in a separate sub-module.

Parameters:
WIDTH, 64, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AW, $clog2(DEPTH), derived pointer width; never overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush: pointers, counts and sticky status return to reset values
wen  input  1  write request
wdata  input  WIDTH  write data
ren  input  1  read request (pops the current head)
rdata  output  WIDTH  head entry; all zeros when empty
empty  output  1  no valid entries
full  output  1  DEPTH valid entries
used_slots  output  AW+1  valid entry count, 0..DEPTH
free_slots  output  AW+1  DEPTH - used_slots
afull_thresh  input  AW+1  almost_full asserts when used_slots >= afull_thresh
aempty_thresh  input  AW+1  almost_empty asserts when used_slots <= aempty_thresh
almost_full  output  1  registered watermark flag
almost_empty  output  1  registered watermark flag
overflow  output  1  one-cycle pulse: write dropped
underflow  output  1  one-cycle pulse: read ignored
err_status  output  2  sticky {overflow_seen, underflow_seen}; cleared by clear or reset
par_err  output  1  parity mismatch on head (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr = rptr = 0, used_slots = 0, free_slots = DEPTH.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0, err_status = 0, par_err = 0, rdata = 0.
  - Memory contents are not reset.
- Write is accepted when wen && (!full || ren_accepted). The word is stored at wptr; wptr increments mod DEPTH.
- Read is accepted when ren && !empty. rptr increments mod DEPTH.
- rdata is combinational from mem[rptr], gated to zero when empty.
  - A written word is visible on rdata the cycle after the write (no fall-through).
- Count update:
  - used_slots += write_accepted - read_accepted.
  - empty, full, used_slots and free_slots are registered and update together on the same edge.
- Simultaneous events:
  - wen && ren when full: both accepted, count stays DEPTH, no overflow.
  - wen && ren when empty: write accepted, read ignored, underflow pulses, count becomes 1.
- Errors:
  - wen && !write_accepted: overflow = 1 on the next cycle, err_status[1] set.
  - ren && empty: underflow = 1 on the next cycle, err_status[0] set.
  - Data and pointers are unchanged in both cases.
- clear has priority over wen/ren in the same cycle:
  - Returns all state to reset values on the next edge.
  - No overflow/underflow pulse is generated for requests in that cycle.
- Watermarks:
  - Flags are computed from the next-state count, so they are coincident with used_slots.
  - Threshold changes take effect one cycle later.
  - afull_thresh = 0 gives almost_full constantly 1.
  - aempty_thresh >= DEPTH gives almost_empty constantly 1.
- Wrap-around: pointers roll from DEPTH-1 to 0. The count (AW+1 bits) disambiguates full from empty.

Optional Feature:
- Macro: NX_FIFO_PARITY_EN.
- Defined:
  - Each entry stores WIDTH+1 bits; the extra bit is the even parity of wdata.
  - par_err = !empty && (^mem[rptr] != 0), combinational.
  - A parity error also sets a sticky bit, so err_status widens to 3 bits: {parity_seen, overflow_seen, underflow_seen}.
- Undefined:
  - Storage is WIDTH bits wide and par_err is tied 0.
  - err_status is 2 bits as listed.

Decomposition:
- Package nx_fifo_pkg:
  - ERR_OVF / ERR_UNF / ERR_PAR bit-index constants.
  - Function fifo_cnt_next(cnt, wacc, racc).
  - Typedef for the err_status vector.
- Sub-module nx_fifo_ctrl_wm holds pointers, count, full/empty, watermarks and error logic.
- The top module instantiates the controller plus the memory array or primitive.

Test Plan:
- Reset, then 16 writes 0x0..0xF with no reads (DEPTH=16):
  - full = 1 after the 16th edge, used_slots = 16, free_slots = 0.
  - A 17th write pulses overflow once and sets err_status = 2'b10.
- Fill to 16, then hold wen = ren = 1 for 20 cycles with an incrementing pattern:
  - full stays 1, no overflow.
  - rdata sequence is in order across the pointer wrap.
- Empty FIFO with wen = ren = 1 and wdata = 0xA5:
  - underflow pulses and count = 1.
  - On the next cycle rdata = 0xA5 and underflow_seen is set.
- afull_thresh = 12, aempty_thresh = 3, write one word at a time:
  - almost_empty drops when used_slots goes 3->4.
  - almost_full rises when used_slots goes 11->12.
- Fill 7 words, pulse clear together with wen:
  - Next cycle empty = 1, used_slots = 0, err_status = 0, rdata = 0, no pulses.
- Assert rst_n low mid-burst between edges:
  - Outputs go immediately to reset values.
  - With NX_FIFO_PARITY_EN, a forced bit-flip in the head entry gives par_err = 1.
